// File: rtl/bcd_disp_pkg.sv
// bcd_disp_pkg: active-low 7-segment codes {g..a} for digits 0..9 and blank, plus bcd_valid() digit range check
package bcd_disp_pkg;
  localparam int MAX_DIGITS = 6;
  localparam logic [6:0] SEG_0 = 7'b100_0000;
  localparam logic [6:0] SEG_1 = 7'b111_1001;
  localparam logic [6:0] SEG_2 = 7'b010_0100;
  localparam logic [6:0] SEG_3 = 7'b011_0000;
  localparam logic [6:0] SEG_4 = 7'b001_1001;
  localparam logic [6:0] SEG_5 = 7'b001_0010;
  localparam logic [6:0] SEG_6 = 7'b000_0010;
  localparam logic [6:0] SEG_7 = 7'b111_1000;
  localparam logic [6:0] SEG_8 = 7'b000_0000;
  localparam logic [6:0] SEG_9 = 7'b001_0000;
  localparam logic [6:0] SEG_BLANK = 7'b111_1111;
  function automatic logic bcd_valid(input logic [4*MAX_DIGITS-1:0] v);
    bcd_valid = 1'b1;
    for (int i = 0; i < MAX_DIGITS; i++)
      if (v[4*i+:4] > 4'd9) bcd_valid = 1'b0;
  endfunction
endpackage

// File: rtl/seg7_dec.sv
// seg7_dec: combinational decoder, bcd[3:0] in, seg[6:0] active-low {g..a} out, blank for values above 9
module seg7_dec
  import bcd_disp_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);
  always_comb begin
    case (bcd)
      4'd0: seg = SEG_0;
      4'd1: seg = SEG_1;
      4'd2: seg = SEG_2;
      4'd3: seg = SEG_3;
      4'd4: seg = SEG_4;
      4'd5: seg = SEG_5;
      4'd6: seg = SEG_6;
      4'd7: seg = SEG_7;
      4'd8: seg = SEG_8;
      4'd9: seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end
endmodule

// File: rtl/bcd_cnt_mod_prog.sv
// bcd_cnt_mod_prog: N-digit BCD up/down counter; sys_clk/sys_rst, cnt_en/cnt_dir control, mod_load/mod_value modulus load, num_bcd/seg/tick/wrap/mod_err outputs
module bcd_cnt_mod_prog
  import bcd_disp_pkg::*;
#(
  parameter int DIGITS = 3,
  parameter int DIV_WIDTH = 26,
  parameter int DIV_COEFF = 50_000_000,
  parameter logic [4*DIGITS-1:0] MOD_DEFAULT = 12'h149
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst,
  input  logic                  cnt_en,
  input  logic                  cnt_dir,
  input  logic                  mod_load,
  input  logic [4*DIGITS-1:0]   mod_value,
  output logic [4*DIGITS-1:0]   num_bcd,
  output logic [7*DIGITS-1:0]   seg,
  output logic                  tick,
  output logic                  wrap,
  output logic                  mod_err
);
  localparam int W = 4 * DIGITS;
  logic [DIV_WIDTH-1:0] div;
  logic [W-1:0] mod_reg, up, dn, nxt;
  logic [7*DIGITS-1:0] seg_c;
  logic div_last, tick_now, at_end, ld_ok;
  assign div_last = div == DIV_WIDTH'(DIV_COEFF - 1);
  assign tick_now = cnt_en && div_last;
  always_comb begin
    logic c, b;
    c = 1'b1;
    b = 1'b1;
    up = num_bcd;
    dn = num_bcd;
    for (int i = 0; i < DIGITS; i++) begin
      up[4*i+:4] = c ? (num_bcd[4*i+:4] == 4'd9 ? 4'd0 : num_bcd[4*i+:4] + 4'd1) : num_bcd[4*i+:4];
      dn[4*i+:4] = b ? (num_bcd[4*i+:4] == 4'd0 ? 4'd9 : num_bcd[4*i+:4] - 4'd1) : num_bcd[4*i+:4];
      c = c && num_bcd[4*i+:4] == 4'd9;
      b = b && num_bcd[4*i+:4] == 4'd0;
    end
  end
  assign at_end = cnt_dir ? num_bcd == '0 : num_bcd == mod_reg;
  assign nxt = at_end ? (cnt_dir ? mod_reg : '0) : (cnt_dir ? dn : up);
  assign ld_ok = bcd_valid((4*MAX_DIGITS)'(mod_value));
  for (genvar g = 0; g < DIGITS; g++) begin : g_dec
    seg7_dec u_dec (.bcd(num_bcd[4*g+:4]), .seg(seg_c[7*g+:7]));
  end
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      div <= '0;
      num_bcd <= '0;
      mod_reg <= MOD_DEFAULT;
      tick <= 1'b0;
      wrap <= 1'b0;
      mod_err <= 1'b0;
      seg <= {DIGITS{SEG_0}};
    end else begin
      if (cnt_en) div <= div_last ? '0 : div + 1'b1;
      tick <= tick_now && !mod_load;
      wrap <= tick_now && !mod_load && at_end;
      seg <= seg_c;
      if (mod_load) begin
        if (ld_ok) begin
          mod_reg <= mod_value;
          mod_err <= 1'b0;
          if (num_bcd > mod_value) num_bcd <= '0;
        end else begin
          mod_err <= 1'b1;
        end
      end else if (tick_now) begin
        num_bcd <= nxt;
      end
    end
  end
endmodule

// File: tb/tb_bcd_cnt_mod_prog.sv
// tb_bcd_cnt_mod_prog: vector table, corner sequences and random stimulus against an integer reference model
module tb_bcd_cnt_mod_prog;
  localparam int DIVC = 4;
  localparam logic [6:0] SEG_TAB [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
  logic sys_clk = 1'b0;
  logic sys_rst, cnt_en, cnt_dir, mod_load;
  logic [11:0] mod_value, num_bcd;
  logic [20:0] seg;
  logic tick, wrap, mod_err;
  int n_chk = 0, n_fail = 0;
  int m_div, m_cnt, m_mod;
  logic m_err, m_tick, m_wrap;
  logic [20:0] m_seg;
  typedef struct packed {
    logic r, e, d, l;
    logic [11:0] v, num;
    logic tk, wr, err;
  } vec_t;
  vec_t tab [16];
  bcd_cnt_mod_prog #(.DIGITS(3), .DIV_WIDTH(4), .DIV_COEFF(DIVC), .MOD_DEFAULT(12'h149)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .cnt_en(cnt_en), .cnt_dir(cnt_dir),
    .mod_load(mod_load), .mod_value(mod_value), .num_bcd(num_bcd), .seg(seg),
    .tick(tick), .wrap(wrap), .mod_err(mod_err)
  );
  always #5 sys_clk = ~sys_clk;
  function automatic logic [11:0] int2bcd(input int c);
    int2bcd = 12'(((c / 100) % 10) * 256 + ((c / 10) % 10) * 16 + c % 10);
  endfunction
  function automatic int bcd2int(input logic [11:0] v);
    bcd2int = int'(v[11:8]) * 100 + int'(v[7:4]) * 10 + int'(v[3:0]);
  endfunction
  function automatic logic is_valid(input logic [11:0] v);
    is_valid = v[11:8] <= 4'd9 && v[7:4] <= 4'd9 && v[3:0] <= 4'd9;
  endfunction
  function automatic logic [20:0] enc(input int c);
    enc = {SEG_TAB[(c / 100) % 10], SEG_TAB[(c / 10) % 10], SEG_TAB[c % 10]};
  endfunction
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic step(input logic r, input logic e, input logic d, input logic l, input logic [11:0] v);
    logic tk;
    sys_rst = r; cnt_en = e; cnt_dir = d; mod_load = l; mod_value = v;
    if (r) begin
      m_div = 0; m_cnt = 0; m_mod = 149; m_err = 0; m_tick = 0; m_wrap = 0; m_seg = enc(0);
    end else begin
      tk = e && m_div == DIVC - 1;
      if (e) m_div = (m_div + 1) % DIVC;
      m_seg = enc(m_cnt);
      m_tick = tk && !l;
      m_wrap = m_tick && (d ? m_cnt == 0 : m_cnt == m_mod);
      if (l) begin
        if (is_valid(v)) begin
          m_mod = bcd2int(v);
          m_err = 0;
          if (m_cnt > m_mod) m_cnt = 0;
        end else m_err = 1;
      end else if (tk) m_cnt = d ? (m_cnt == 0 ? m_mod : m_cnt - 1) : (m_cnt == m_mod ? 0 : m_cnt + 1);
    end
    @(posedge sys_clk);
    #1;
    chk("model_num", 32'(num_bcd), 32'(int2bcd(m_cnt)));
    chk("model_tick", 32'(tick), 32'(m_tick));
    chk("model_wrap", 32'(wrap), 32'(m_wrap));
    chk("model_err", 32'(mod_err), 32'(m_err));
    chk("model_seg", 32'(seg), 32'(m_seg));
  endtask
  task automatic run_ticks(input int n, input logic d);
    int seen = 0;
    for (int i = 0; i < n * DIVC + DIVC && seen < n; i++) begin
      step(0, 1, d, 0, 12'h0);
      if (m_tick) seen++;
    end
    chk("tick_budget", 32'(seen), 32'(n));
  endtask
  initial begin
    logic r, e, d, l;
    logic [11:0] v;
    tab[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 12'h000, 12'h000, 1'b0, 1'b0, 1'b0};
    tab[1]  = '{1'b0, 1'b1, 1'b0, 1'b0, 12'h000, 12'h000, 1'b0, 1'b0, 1'b0};
    tab[2]  = '{1'b0, 1'b1, 1'b0, 1'b0, 12'h000, 12'h000, 1'b0, 1'b0, 1'b0};
    tab[3]  = '{1'b0, 1'b1, 1'b0, 1'b0, 12'h000, 12'h000, 1'b0, 1'b0, 1'b0};
    tab[4]  = '{1'b0, 1'b1, 1'b0, 1'b0, 12'h000, 12'h001, 1'b1, 1'b0, 1'b0};
    tab[5]  = '{1'b0, 1'b1, 1'b0, 1'b0, 12'h000, 12'h001, 1'b0, 1'b0, 1'b0};
    tab[6]  = '{1'b0, 1'b1, 1'b0, 1'b1, 12'h1A0, 12'h001, 1'b0, 1'b0, 1'b1};
    tab[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 12'h000, 12'h001, 1'b0, 1'b0, 1'b1};
    tab[8]  = '{1'b0, 1'b1, 1'b1, 1'b0, 12'h000, 12'h001, 1'b0, 1'b0, 1'b1};
    tab[9]  = '{1'b0, 1'b1, 1'b1, 1'b0, 12'h000, 12'h000, 1'b1, 1'b0, 1'b1};
    tab[10] = '{1'b0, 1'b1, 1'b1, 1'b0, 12'h000, 12'h000, 1'b0, 1'b0, 1'b1};
    tab[11] = '{1'b0, 1'b1, 1'b1, 1'b0, 12'h000, 12'h000, 1'b0, 1'b0, 1'b1};
    tab[12] = '{1'b0, 1'b1, 1'b1, 1'b0, 12'h000, 12'h000, 1'b0, 1'b0, 1'b1};
    tab[13] = '{1'b0, 1'b1, 1'b1, 1'b0, 12'h000, 12'h149, 1'b1, 1'b1, 1'b1};
    tab[14] = '{1'b0, 1'b1, 1'b1, 1'b1, 12'h050, 12'h000, 1'b0, 1'b0, 1'b0};
    tab[15] = '{1'b0, 1'b1, 1'b1, 1'b0, 12'h000, 12'h000, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 16; i++) begin
      step(tab[i].r, tab[i].e, tab[i].d, tab[i].l, tab[i].v);
      chk($sformatf("vec%0d_num", i), 32'(num_bcd), 32'(tab[i].num));
      chk($sformatf("vec%0d_tick", i), 32'(tick), 32'(tab[i].tk));
      chk($sformatf("vec%0d_wrap", i), 32'(wrap), 32'(tab[i].wr));
      chk($sformatf("vec%0d_err", i), 32'(mod_err), 32'(tab[i].err));
    end
    chk("vec0_seg_reset", 32'(seg), 32'({3{7'h40}}));
    step(1, 0, 0, 0, 12'h0);
    run_ticks(87, 0);
    chk("count_87", 32'(num_bcd), 32'h087);
    step(0, 1, 0, 1, 12'h050);
    chk("clamp_num", 32'(num_bcd), 32'h000);
    chk("clamp_err", 32'(mod_err), 32'h0);
    step(0, 1, 0, 1, 12'h1A0);
    chk("bad_load_err", 32'(mod_err), 32'h1);
    run_ticks(50, 0);
    chk("mod50_top", 32'(num_bcd), 32'h050);
    run_ticks(1, 0);
    chk("mod50_wrap_num", 32'(num_bcd), 32'h000);
    chk("mod50_wrap", 32'(wrap), 32'h1);
    step(0, 1, 0, 1, 12'h060);
    chk("good_load_err", 32'(mod_err), 32'h0);
    step(1, 0, 0, 0, 12'h0);
    run_ticks(20, 0);
    for (int i = 0; i < DIVC && m_div != DIVC - 1; i++) step(0, 1, 0, 0, 12'h0);
    chk("collide_align", 32'(m_div), 32'(DIVC - 1));
    step(0, 1, 0, 1, 12'h100);
    chk("collide_num", 32'(num_bcd), 32'h020);
    chk("collide_tick", 32'(tick), 32'h0);
    run_ticks(1, 0);
    chk("collide_next", 32'(num_bcd), 32'h021);
    step(1, 0, 0, 0, 12'h0);
    run_ticks(123, 0);
    chk("count_123", 32'(num_bcd), 32'h123);
    step(0, 1, 0, 0, 12'h0);
    step(0, 0, 0, 0, 12'h0);
    step(0, 0, 0, 0, 12'h0);
    chk("hold_num", 32'(num_bcd), 32'h123);
    step(1, 1, 0, 1, 12'h050);
    chk("rst_num", 32'(num_bcd), 32'h000);
    chk("rst_seg", 32'(seg), 32'({3{7'h40}}));
    chk("rst_err", 32'(mod_err), 32'h0);
    run_ticks(1, 1);
    chk("rst_mod_149", 32'(num_bcd), 32'h149);
    chk("down_wrap", 32'(wrap), 32'h1);
    run_ticks(1, 0);
    chk("up_wrap_num", 32'(num_bcd), 32'h000);
    chk("up_wrap", 32'(wrap), 32'h1);
    step(0, 1, 0, 1, 12'h000);
    for (int i = 0; i < 3; i++) begin
      run_ticks(1, 1'(i));
      chk("mod0_num", 32'(num_bcd), 32'h000);
      chk("mod0_wrap", 32'(wrap), 32'h1);
    end
    step(1, 0, 0, 0, 12'h0);
    d = 0;
    for (int i = 0; i < 4000; i++) begin
      r = $urandom_range(0, 299) == 0;
      e = $urandom_range(0, 6) != 0;
      if ($urandom_range(0, 63) == 0) d = ~d;
      l = $urandom_range(0, 39) == 0;
      v = $urandom_range(0, 1) ? int2bcd(int'($urandom_range(0, 999))) : 12'($urandom);
      step(r, e, d, l, v);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/bcd_cnt_mod_prog.md
Name: bcd_cnt_mod_prog

Overview:
Parametrised successor to the fixed two-modulus BCD counter. It provides an N-digit BCD up/down counter with a runtime-loadable modulus, an internal tick divider used as a clock enable (no derived clock), and registered per-digit 7-segment outputs. It sits between the board switches and buttons and the nixie/7-seg display bank.

Parameters:
DIGITS, 3, number of BCD digits (1..6).
DIV_WIDTH, 26, bit width of the tick divider.
DIV_COEFF, 50_000_000, sys_clk cycles per count tick (1 s at 50 MHz); must be at least 1.
MOD_DEFAULT, 12'h149, BCD modulus loaded at reset (max count 149); width is 4*DIGITS.

Ports:
sys_clk  in  1  system clock, 50 MHz
sys_rst  in  1  synchronous reset, active-high
cnt_en  in  1  1 = divider and counter run; 0 = both hold
cnt_dir  in  1  0 = count up, 1 = count down
mod_load  in  1  one-cycle strobe: capture mod_value
mod_value  in  4*DIGITS  new maximum count, BCD
num_bcd  out  4*DIGITS  current count, BCD, registered
seg  out  7*DIGITS  active-low segments {g..a}; digit k occupies [7k+6:7k]
tick  out  1  one-cycle pulse when the counter advances
wrap  out  1  one-cycle pulse, coincident with tick, on wrap-around
mod_err  out  1  sticky flag: last load was rejected

Behaviour:
- Clock and reset: one clock, sys_clk. Reset is synchronous and active-high on sys_rst.
- Reset values: divider 0, num_bcd 0, mod_reg MOD_DEFAULT, tick 0, wrap 0, mod_err 0, every seg digit 7'b100_0000 ("0").
- Divider:
  - When cnt_en=1, counts 0..DIV_COEFF-1. At DIV_COEFF-1 it returns to 0 and asserts tick for the following cycle.
  - When cnt_en=0, the divider holds its value and tick=0.
- Count range: 0..mod_reg inclusive. Comparisons are done on the packed BCD vector as an unsigned value; this is valid because all digits are 0..9.
- On a tick cycle with cnt_dir=0 (up):
  - If num_bcd == mod_reg: num_bcd <= 0 and wrap=1.
  - Otherwise BCD increment: the lowest digit of 9 goes to 0 and carries; the carry ripples through all DIGITS.
- On a tick cycle with cnt_dir=1 (down):
  - If num_bcd == 0: num_bcd <= mod_reg and wrap=1.
  - Otherwise BCD decrement: the lowest digit of 0 goes to 9 and borrows.
- Latency: num_bcd updates in the same edge that registers tick. seg reflects num_bcd one cycle later.
- Modulus load (mod_load=1):
  - If every digit of mod_value is ≤9: mod_reg <= mod_value and mod_err <= 0. If num_bcd > mod_value, num_bcd <= 0.
  - Otherwise (any digit >9): mod_reg is unchanged and mod_err <= 1. mod_err stays set until the next valid load or reset.
- Load and tick in the same cycle: the load has priority and the count does not advance. tick and wrap are suppressed in that cycle, and the divider still wraps normally.
- mod_reg = 0 is legal. The count stays at 0, and wrap pulses on every tick in either direction.
- cnt_dir changes take effect on the next tick. No glitch or extra step is allowed.
- Segment encoding (active-low): 0:1000000, 1:1111001, 2:0100100, 3:0110000, 4:0011001, 5:0010010, 6:0000010, 7:1111000, 8:0000000, 9:0010000. Any other digit value gives 1111111 (unreachable in normal operation).
- Reset mid-operation: all state returns to reset values on the next edge. Any pending load is discarded.

Decomposition:
- Package bcd_disp_pkg:
  - SEG_* encoding constants for digits 0..9 and blank.
  - Function bcd_valid(vector) returning whether every digit is ≤9.
- Sub-module seg7_dec: combinational, one BCD digit in, 7 segments out, active-low. Instantiated DIGITS times with a generate loop; outputs registered in the parent.
- Divider, counter and modulus register stay in the parent.

Test Plan:
1. Up-count wrap: DIV_COEFF=4, reset, cnt_en=1, dir=0, default modulus -> one tick every 4 cycles; 009->010, 099->100; 149->000 with wrap=1.
2. Down-count wrap: dir=1 from 000 -> next tick gives 149 with wrap=1; 100->099, 010->009.
3. Load and clamp: count at 087, load 12'h050 -> mod_reg=050, num_bcd=000, mod_err=0. Load 12'h1A0 -> mod_err=1, mod_reg stays 050. Load 12'h060 -> mod_err=0.
4. Load-tick collision: mod_load asserted exactly on a tick cycle at 020 with mod_value 12'h100 -> num_bcd stays 020, tick=0; the next tick gives 021.
5. Enable hold and reset: drop cnt_en mid-divide -> num_bcd and divider frozen. Re-enable -> the tick arrives after the remaining cycles. Assert sys_rst at count 123 -> next edge num_bcd=000, seg=3×1000000, mod_reg=149.
6. Segment check: step through 0..9 in each digit -> seg matches the encoding table one cycle after num_bcd.
